// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle core: opcode/funct encodings,
// control FSM states, ALU operations and the decoded instruction class.
package multicycle_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_PASSB
  } alu_op_t;

  // Instruction class drives the EXEC/MEM/WB sequencing.
  typedef enum logic [2:0] {
    CL_ALU, CL_BEQ, CL_BNE, CL_JMP, CL_LOAD, CL_STORE, CL_HALT, CL_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle core.
// Ports: op (operation), a/b (operands), result, zero (result == 0).
module mc_alu
  import multicycle_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_SLT:   result = DATA_W'($signed(a) < $signed(b));
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// Multicycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT control FSM with an
// inline register file (r0 reads as zero) and req/ready memory ports.
// Ports: clk, reset (async, active low); imem_* instruction fetch port;
// dmem_* data port; halted, illegal (sticky), retire (per-instruction
// pulse), pc_out (debug PC).
module multicycle_core
  import multicycle_pkg::*;
#(
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      NREGS    = 32,
  parameter int unsigned      ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              halted,
  output logic              illegal,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  state_t            state, state_nx;
  iclass_t           cls;
  alu_op_t           alu_op;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, a_reg, b_reg, alu_out, mdr;
  logic [DATA_W-1:0] regs [NREGS];
  logic [OP_W-1:0]   opcode, funct;
  logic [RIDX_W-1:0] r1, r2, r3;
  logic [DATA_W-1:0] imm_se, lui_val, rd1, rd2, rd3;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic              alu_zero, use_imm, br_taken, fetch_done, mem_done;

  assign opcode  = ir[31:26];
  assign funct   = ir[5:0];
  assign r1      = ir[21 +: RIDX_W];
  assign r2      = ir[16 +: RIDX_W];
  assign r3      = ir[11 +: RIDX_W];
  assign imm_se  = DATA_W'($signed(ir[15:0]));
  assign lui_val = DATA_W'({ir[15:0], 16'h0000});

  assign fetch_done = imem_req && imem_ready;
  assign mem_done   = dmem_req && dmem_ready;

  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign dmem_addr  = alu_out[ADDR_W-1:0];
  assign dmem_wdata = a_reg;

  // Register file read ports; index 0 always reads zero.
  always_comb begin
    rd1 = (r1 == '0) ? '0 : regs[r1];
    rd2 = (r2 == '0) ? '0 : regs[r2];
    rd3 = (r3 == '0) ? '0 : regs[r3];
  end

  // Instruction decode into class and ALU operation.
  always_comb begin
    cls    = CL_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        cls = CL_ALU;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: cls = CL_ILLEGAL;
        endcase
      end
      OP_ADDI: cls = CL_ALU;
      OP_LUI:  begin cls = CL_ALU; alu_op = ALU_PASSB; end
      OP_LW:   cls = CL_LOAD;
      OP_SW:   cls = CL_STORE;
      OP_BEQ:  begin cls = CL_BEQ; alu_op = ALU_SUB; end
      OP_BNE:  begin cls = CL_BNE; alu_op = ALU_SUB; end
      OP_J:    cls = CL_JMP;
      OP_HALT: cls = CL_HALT;
      default: cls = CL_ILLEGAL;
    endcase
  end

  // A holds reg[r1] (store data / branch operand) except for R-type, where
  // A/B hold the two sources reg[r2]/reg[r3]. Immediate forms use B as base.
  assign use_imm = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
  assign alu_a   = use_imm ? b_reg : a_reg;
  assign alu_b   = use_imm ? imm_se : ((opcode == OP_LUI) ? lui_val : b_reg);

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign br_taken = ((cls == CL_BEQ) && alu_zero) || ((cls == CL_BNE) && !alu_zero);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_nx;
  end

  // Next-state and retire decode.
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      ST_FETCH:  if (fetch_done) state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CL_BEQ, CL_BNE, CL_JMP: begin state_nx = ST_FETCH; retire = 1'b1; end
          CL_LOAD, CL_STORE:      state_nx = ST_MEM;
          CL_HALT, CL_ILLEGAL:    state_nx = ST_HALT;
          default:                state_nx = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_done) begin
          if (cls == CL_STORE) begin state_nx = ST_FETCH; retire = 1'b1; end
          else                 state_nx = ST_WB;
        end
      end
      ST_WB:   begin state_nx = ST_FETCH; retire = 1'b1; end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_HALT;
    endcase
  end

  // Datapath registers and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      illegal  <= 1'b0;
      halted   <= 1'b0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end else begin
      imem_req <= (state_nx == ST_FETCH);
      dmem_req <= (state_nx == ST_MEM);
      dmem_we  <= (state_nx == ST_MEM) && (cls == CL_STORE);
      halted   <= (state_nx == ST_HALT);
      case (state)
        ST_FETCH: begin
          if (fetch_done) begin
            ir <= imem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        ST_DECODE: begin
          a_reg <= (opcode == OP_RTYPE) ? rd2 : rd1;
          b_reg <= (opcode == OP_RTYPE) ? rd3 : rd2;
        end
        ST_EXEC: begin
          alu_out <= alu_res;
          // PC already points past the branch, so target is PC + SE(imm).
          if (br_taken)          pc <= pc + imm_se[ADDR_W-1:0];
          if (cls == CL_JMP)     pc <= ir[ADDR_W-1:0];
          if (cls == CL_ILLEGAL) illegal <= 1'b1;
        end
        ST_MEM: if (mem_done && (cls == CL_LOAD)) mdr <= dmem_rdata;
        default: ;
      endcase
    end
  end

  // Register file write port; writes to r0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if ((state == ST_WB) && (r1 != '0)) begin
      regs[r1] <= (cls == CL_LOAD) ? mdr : alu_out;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed testbench for multicycle_core with wait-state memory models.
module tb_multicycle_core;

  localparam logic [31:0] W_HALT = 32'hFC00_0000;
  localparam logic [31:0] W_NOP  = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [15:0] imem_addr, dmem_addr, pc_out;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
  logic        halted, illegal, retire;

  logic [31:0] imem [65536];
  logic [31:0] dmem [256];
  int          imem_wait = 0, dmem_wait = 0;
  int          icnt = 0, dcnt = 0;
  logic        stall_en = 1'b0;
  int          cyc = 0;
  int          first_fetch = -1;
  int          checks = 0, failures = 0;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } dsamp_t;

  int          ret_q[$];
  logic [15:0] f_q[$];
  dsamp_t      d_q[$];

  multicycle_core dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .halted(halted), .illegal(illegal), .retire(retire), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  assign imem_ready = imem_req && (icnt >= imem_wait) && !(stall_en && imem_addr == 16'h0050);
  assign dmem_ready = dmem_req && (dcnt >= dmem_wait);

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
  end

  // Event logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (retire) ret_q.push_back(cyc);
      if (imem_req && first_fetch < 0) first_fetch = cyc;
      if (imem_req && imem_ready) f_q.push_back(imem_addr);
      if (dmem_req) begin
        d_q.push_back({dmem_we, dmem_addr, dmem_wdata});
        if (dmem_we && dmem_ready) dmem[dmem_addr[7:0]] = dmem_wdata;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] d, s, t);
    return {6'h00, d, s, t, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] d, s, input logic [15:0] imm);
    return {op, d, s, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] a);
    return {6'h02, a};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) imem[i] = W_HALT;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    ret_q.delete(); f_q.delete(); d_q.delete();
    first_fetch = -1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_until_halt(input int maxc, input string name);
    int n = 0;
    while (!halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout halted=%0b expected=1", name, halted);
    end
  endtask

  task automatic test_reset();
    clear_mem();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, dmem_req, halted, illegal, retire} !== 5'b0 || pc_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs req/dreq/halt/ill/ret=%b pc=%h expected=00000 pc=0000",
               {imem_req, dmem_req, halted, illegal, retire}, pc_out);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      failures++;
      $display("FAIL reset_first_fetch req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
    run_until_halt(20, "reset_halt");
    checks++;
    if (illegal !== 1'b0 || ret_q.size() != 0) begin
      failures++;
      $display("FAIL halt_op illegal=%b retires=%0d expected illegal=0 retires=0", illegal, ret_q.size());
    end
  endtask

  task automatic test_alu_chain();
    int exp_rel[3] = '{4, 8, 12};
    clear_mem();
    imem_wait = 0; dmem_wait = 0;
    imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1] = enc_i(6'h08, 5'd2, 5'd0, 16'd7);
    imem[2] = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
    imem[3] = enc_i(6'h2B, 5'd3, 5'd0, 16'h0040);
    do_reset();
    run_until_halt(100, "alu_chain");
    checks++;
    if (dmem[8'h40] !== 32'd12) begin
      failures++;
      $display("FAIL add_result got=%h expected=0000000c", dmem[8'h40]);
    end
    checks++;
    if (ret_q.size() != 4) begin
      failures++;
      $display("FAIL retire_count got=%0d expected=4", ret_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ret_q[i] - first_fetch + 1 != exp_rel[i]) begin
          failures++;
          $display("FAIL retire_cycle_%0d got=%0d expected=%0d", i, ret_q[i] - first_fetch + 1, exp_rel[i]);
        end
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_v[5] = '{32'hFFFF_FFF8, 32'h5, 32'hFFFF_FFFD, 32'h1, 32'h0};
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'hFFFD);
    imem[1] = enc_i(6'h08, 5'd2, 5'd0, 16'd5);
    imem[2] = enc_r(6'h22, 5'd3, 5'd1, 5'd2);
    imem[3] = enc_r(6'h24, 5'd4, 5'd1, 5'd2);
    imem[4] = enc_r(6'h25, 5'd5, 5'd1, 5'd2);
    imem[5] = enc_r(6'h2A, 5'd6, 5'd1, 5'd2);
    imem[6] = enc_r(6'h2A, 5'd7, 5'd2, 5'd1);
    for (int i = 0; i < 5; i++) imem[7+i] = enc_i(6'h2B, 5'(3+i), 5'd0, 16'(8'h30 + i));
    dmem[8'h34] = 32'hFFFF_FFFF;
    do_reset();
    run_until_halt(200, "alu_ops");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dmem[8'h30 + i] !== exp_v[i]) begin
        failures++;
        $display("FAIL alu_op_%0d got=%h expected=%h", i, dmem[8'h30 + i], exp_v[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic ok_sw = 1'b1, ok_lw = 1'b1, ok_sw2 = 1'b1;
    clear_mem();
    dmem_wait = 3;
    imem[0] = enc_i(6'h08, 5'd3, 5'd0, 16'd12);
    imem[1] = enc_i(6'h2B, 5'd3, 5'd0, 16'h0010);
    imem[2] = enc_i(6'h23, 5'd4, 5'd0, 16'h0010);
    imem[3] = enc_i(6'h2B, 5'd4, 5'd0, 16'h0011);
    do_reset();
    run_until_halt(200, "mem_wait");
    dmem_wait = 0;
    checks++;
    if (d_q.size() != 12) begin
      failures++;
      $display("FAIL dmem_req_cycles got=%0d expected=12", d_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (d_q[i] !== {1'b1, 16'h0010, 32'd12}) ok_sw = 1'b0;
        if (d_q[4+i].we !== 1'b0 || d_q[4+i].addr !== 16'h0010) ok_lw = 1'b0;
        if (d_q[8+i] !== {1'b1, 16'h0011, 32'd12}) ok_sw2 = 1'b0;
      end
      checks++;
      if ({ok_sw, ok_lw, ok_sw2} !== 3'b111) begin
        failures++;
        $display("FAIL dmem_hold_stable sw/lw/sw=%b expected=111", {ok_sw, ok_lw, ok_sw2});
      end
    end
    checks++;
    if (dmem[8'h11] !== 32'd12 || dmem[8'h10] !== 32'd12) begin
      failures++;
      $display("FAIL load_value got=%h/%h expected=0000000c/0000000c", dmem[8'h10], dmem[8'h11]);
    end
    checks++;
    if (ret_q.size() != 4) begin
      failures++;
      $display("FAIL mem_retire_count got=%0d expected=4", ret_q.size());
    end else begin
      checks++;
      if (ret_q[1] - ret_q[0] != 7 || ret_q[2] - ret_q[1] != 8) begin
        failures++;
        $display("FAIL mem_latency sw=%0d lw=%0d expected sw=7 lw=8", ret_q[1] - ret_q[0], ret_q[2] - ret_q[1]);
      end
    end
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL halt_not_illegal got=%b expected=0", illegal);
    end
  endtask

  task automatic run_branch(input logic [31:0] br, input logic [15:0] exp_next, input string name);
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd3);
    imem[1] = W_NOP; imem[2] = W_NOP; imem[3] = W_NOP;
    imem[4] = br;
    do_reset();
    repeat (40) @(negedge clk);
    checks++;
    if (f_q.size() < 6) begin
      failures++;
      $display("FAIL %s_fetches got=%0d expected>=6", name, f_q.size());
    end else begin
      checks++;
      if (f_q[4] !== 16'd4 || f_q[5] !== exp_next) begin
        failures++;
        $display("FAIL %s_next_fetch got=%h after %h expected=%h after 0004", name, f_q[5], f_q[4], exp_next);
      end
      checks++;
      if (ret_q.size() < 5 || ret_q[4] - ret_q[3] != 3) begin
        failures++;
        $display("FAIL %s_latency retires=%0d expected branch latency 3", name, ret_q.size());
      end
    end
  endtask

  task automatic test_branch();
    run_branch(enc_i(6'h04, 5'd1, 5'd1, 16'd2), 16'd7, "beq_taken");
    run_branch(enc_i(6'h05, 5'd1, 5'd1, 16'd2), 16'd5, "bne_not_taken");
    run_branch(enc_i(6'h05, 5'd1, 5'd0, 16'hFFFB), 16'd0, "bne_back");
  endtask

  task automatic test_r0_lui();
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    imem[1] = enc_r(6'h20, 5'd5, 5'd0, 5'd0);
    imem[2] = enc_i(6'h0F, 5'd6, 5'd0, 16'hABCD);
    imem[3] = enc_i(6'h2B, 5'd5, 5'd0, 16'h0020);
    imem[4] = enc_i(6'h2B, 5'd6, 5'd0, 16'h0021);
    dmem[8'h20] = 32'hDEAD_BEEF;
    do_reset();
    run_until_halt(200, "r0_lui");
    checks++;
    if (dmem[8'h20] !== 32'h0) begin
      failures++;
      $display("FAIL reg0_zero got=%h expected=00000000", dmem[8'h20]);
    end
    checks++;
    if (dmem[8'h21] !== 32'hABCD_0000) begin
      failures++;
      $display("FAIL lui got=%h expected=abcd0000", dmem[8'h21]);
    end
  endtask

  task automatic test_illegal();
    int req_seen = 0;
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
    imem[1] = 32'hF800_0000;
    imem[2] = enc_i(6'h08, 5'd2, 5'd0, 16'd1);
    do_reset();
    run_until_halt(100, "illegal_op");
    repeat (20) begin
      @(negedge clk);
      if (imem_req) req_seen++;
    end
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || ret_q.size() != 1) begin
      failures++;
      $display("FAIL illegal_op ill=%b halt=%b retires=%0d expected 1 1 1", illegal, halted, ret_q.size());
    end
    checks++;
    if (req_seen != 0) begin
      failures++;
      $display("FAIL halt_req_quiet got=%0d expected=0", req_seen);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0 || halted !== 1'b0 || pc_out !== 16'h0) begin
      failures++;
      $display("FAIL illegal_reset ill=%b halt=%b pc=%h expected 0 0 0000", illegal, halted, pc_out);
    end
    clear_mem();
    imem[0] = enc_r(6'h21, 5'd1, 5'd0, 5'd0);
    do_reset();
    run_until_halt(100, "bad_funct");
    checks++;
    if (illegal !== 1'b1 || ret_q.size() != 0) begin
      failures++;
      $display("FAIL bad_funct ill=%b retires=%0d expected 1 0", illegal, ret_q.size());
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n = 0;
    clear_mem();
    imem[0] = enc_j(26'h50);
    stall_en = 1'b1;
    do_reset();
    while (!(imem_req && imem_addr == 16'h0050) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_fetch req=%b pc=%h expected req=0 pc=0000", imem_req, pc_out);
    end
    stall_en = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (f_q.size() < 1 || f_q[0] !== 16'h0) begin
      failures++;
      $display("FAIL restart_fetch fetches=%0d expected first fetch at 0000", f_q.size());
    end
    clear_mem();
    imem[0] = enc_j(26'hFFFF);
    imem[16'hFFFF] = W_NOP;
    do_reset();
    repeat (20) @(negedge clk);
    checks++;
    if (f_q.size() < 3 || f_q[1] !== 16'hFFFF || f_q[2] !== 16'h0000) begin
      failures++;
      $display("FAIL pc_wrap fetches=%0d expected 0000,ffff,0000", f_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_alu_ops();
    test_mem_wait();
    test_branch();
    test_r0_lui();
    test_illegal();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
